// File: rtl/const_def.sv
// Shared constants and types for the reorder buffer and its forwarding ports.
package const_def;

    localparam int DEF_ROB_DEPTH = 16;
    localparam int DEF_TAG_W     = 5;
    localparam int RD_W          = 5;
    localparam int XLEN          = 32;

    // Tag 0 means "no dependency"; entry i carries tag i+1.
    localparam logic [DEF_TAG_W-1:0] NO_TAG = '0;

    typedef enum logic [1:0] {
        ENT_EMPTY  = 2'd0,
        ENT_ISSUED = 2'd1,
        ENT_DONE   = 2'd2
    } ent_state_t;

endpackage

// File: rtl/rob_fwd_port.sv
// One operand-forwarding port: looks a tag up among completed entries and
// falls back to the value currently on the CDB.
module rob_fwd_port
    import const_def::*;
#(
    parameter int ROB_DEPTH = DEF_ROB_DEPTH,
    parameter int TAG_W     = DEF_TAG_W
) (
    input  logic [TAG_W-1:0]     qry_tag,
    input  logic [ROB_DEPTH-1:0] done_mask,
    input  logic [XLEN-1:0]      ent_data [ROB_DEPTH],
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [XLEN-1:0]      cdb_data,
    output logic                 ready,
    output logic [XLEN-1:0]      data
);

    logic hit;

    // Tag 0 is always ready; a completed entry wins over the CDB bypass.
    always_comb begin
        ready = 1'b0;
        data  = '0;
        hit   = 1'b0;
        if (qry_tag == '0) begin
            ready = 1'b1;
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (done_mask[i] && (qry_tag == TAG_W'(i + 1))) begin
                    hit  = 1'b1;
                    data = ent_data[i];
                end
            end
            if (hit) begin
                ready = 1'b1;
            end else if (cdb_valid && (cdb_tag == qry_tag)) begin
                ready = 1'b1;
                data  = cdb_data;
            end
        end
    end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: allocates rename tags, captures CDB results and retires in
// program order, flushing everything on a mispredicted branch.
// Optional macro ROB_STAT_EN adds commit / mispredict counters.
module rob_commit
    import const_def::*;
#(
    parameter int ROB_DEPTH = DEF_ROB_DEPTH,
    parameter int TAG_W     = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             disp_valid,
    input  logic [RD_W-1:0]  disp_rd,
    input  logic             disp_is_branch,
    input  logic             disp_pred_taken,
    input  logic [XLEN-1:0]  disp_alt_pc,
    output logic [TAG_W-1:0] disp_tag,
    output logic             rob_full,
    input  logic [TAG_W-1:0] qry1_tag,
    input  logic [TAG_W-1:0] qry2_tag,
    output logic             qry1_ready,
    output logic             qry2_ready,
    output logic [XLEN-1:0]  qry1_data,
    output logic [XLEN-1:0]  qry2_data,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    input  logic             cdb_taken,
    output logic             commit_valid,
    output logic [RD_W-1:0]  commit_rd,
    output logic [TAG_W-1:0] commit_tag,
    output logic [XLEN-1:0]  commit_data,
    output logic             wrong_commit,
    output logic [XLEN-1:0]  flush_pc
`ifdef ROB_STAT_EN
    ,
    output logic [31:0]      stat_commits,
    output logic [31:0]      stat_mispredicts
`endif
);

    localparam int PTR_W = $clog2(ROB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;

    ent_state_t           ent_state  [ROB_DEPTH];
    logic [RD_W-1:0]      ent_rd     [ROB_DEPTH];
    logic                 ent_branch [ROB_DEPTH];
    logic                 ent_pred   [ROB_DEPTH];
    logic                 ent_taken  [ROB_DEPTH];
    logic [XLEN-1:0]      ent_alt_pc [ROB_DEPTH];
    logic [XLEN-1:0]      ent_data   [ROB_DEPTH];

    logic [ROB_DEPTH-1:0] done_mask;
    logic [ROB_DEPTH-1:0] cdb_sel;
    logic                 do_disp;
    logic                 do_retire;
    logic                 mispredict;

    // Dispatch handshake: the dispatcher offers disp_valid; the ROB accepts on
    // any edge where rdy is high and rob_full is low. rob_full comes from the
    // registered count only, so a slot freed by a retire in the same cycle is
    // not reusable until the following cycle.
    always_comb begin
        rob_full   = (count == CNT_W'(ROB_DEPTH));
        disp_tag   = rob_full ? '0 : TAG_W'(tail) + TAG_W'(1);
        do_disp    = rdy && disp_valid && !rob_full;
        do_retire  = rdy && (count != '0) && (ent_state[head] == ENT_DONE);
        mispredict = do_retire && ent_branch[head] &&
                     (ent_taken[head] != ent_pred[head]);
    end

    // Per-entry status: completed entries and CDB matches on issued entries.
    always_comb begin
        done_mask = '0;
        cdb_sel   = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            done_mask[i] = (ent_state[i] == ENT_DONE);
            cdb_sel[i]   = cdb_valid && (cdb_tag == TAG_W'(i + 1)) &&
                           (ent_state[i] == ENT_ISSUED);
        end
    end

    // Pointers, entry storage and the registered commit interface.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_tag   <= '0;
            commit_data  <= '0;
            wrong_commit <= 1'b0;
            flush_pc     <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent_state[i]  <= ENT_EMPTY;
                ent_rd[i]     <= '0;
                ent_branch[i] <= 1'b0;
                ent_pred[i]   <= 1'b0;
                ent_taken[i]  <= 1'b0;
                ent_alt_pc[i] <= '0;
                ent_data[i]   <= '0;
            end
        end else if (rdy) begin
            commit_valid <= 1'b0;
            wrong_commit <= 1'b0;
            if (do_retire) begin
                commit_valid <= 1'b1;
                commit_rd    <= mispredict ? '0 : ent_rd[head];
                commit_tag   <= TAG_W'(head) + TAG_W'(1);
                commit_data  <= ent_data[head];
                wrong_commit <= mispredict;
                if (mispredict) begin
                    flush_pc <= ent_alt_pc[head];
                end
            end
            if (mispredict) begin
                // Flush wins over any dispatch or CDB write in this cycle.
                head  <= '0;
                tail  <= '0;
                count <= '0;
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    ent_state[i] <= ENT_EMPTY;
                end
            end else begin
                if (do_retire) begin
                    ent_state[head] <= ENT_EMPTY;
                    head            <= head + PTR_W'(1);
                end
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    if (cdb_sel[i]) begin
                        ent_state[i] <= ENT_DONE;
                        ent_data[i]  <= cdb_data;
                        ent_taken[i] <= cdb_taken;
                    end
                end
                if (do_disp) begin
                    ent_state[tail]  <= ENT_ISSUED;
                    ent_rd[tail]     <= disp_is_branch ? '0 : disp_rd;
                    ent_branch[tail] <= disp_is_branch;
                    ent_pred[tail]   <= disp_pred_taken;
                    ent_alt_pc[tail] <= disp_alt_pc;
                    tail             <= tail + PTR_W'(1);
                end
                case ({do_disp, do_retire})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef ROB_STAT_EN
    // Free-running retire and mispredict counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_commits     <= '0;
            stat_mispredicts <= '0;
        end else if (rdy) begin
            if (do_retire) begin
                stat_commits <= stat_commits + 32'd1;
            end
            if (mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

    rob_fwd_port #(
        .ROB_DEPTH (ROB_DEPTH),
        .TAG_W     (TAG_W)
    ) u_fwd1 (
        .qry_tag   (qry1_tag),
        .done_mask (done_mask),
        .ent_data  (ent_data),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .ready     (qry1_ready),
        .data      (qry1_data)
    );

    rob_fwd_port #(
        .ROB_DEPTH (ROB_DEPTH),
        .TAG_W     (TAG_W)
    ) u_fwd2 (
        .qry_tag   (qry2_tag),
        .done_mask (done_mask),
        .ent_data  (ent_data),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .ready     (qry2_ready),
        .data      (qry2_data)
    );

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: reset, in-order retire, full/wrap, flush,
// forwarding, asynchronous reset mid-burst and rdy freeze.
module tb_rob_commit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        rdy;
    logic        disp_valid;
    logic [4:0]  disp_rd;
    logic        disp_is_branch;
    logic        disp_pred_taken;
    logic [31:0] disp_alt_pc;
    logic [4:0]  disp_tag;
    logic        rob_full;
    logic [4:0]  qry1_tag, qry2_tag;
    logic        qry1_ready, qry2_ready;
    logic [31:0] qry1_data, qry2_data;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_taken;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [4:0]  commit_tag;
    logic [31:0] commit_data;
    logic        wrong_commit;
    logic [31:0] flush_pc;
`ifdef ROB_STAT_EN
    logic [31:0] stat_commits;
    logic [31:0] stat_mispredicts;
`endif

    int checks   = 0;
    int failures = 0;
    // Scoreboard entries: {tag, rd, data}
    logic [41:0] exp_q [$];

    rob_commit dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .disp_valid      (disp_valid),
        .disp_rd         (disp_rd),
        .disp_is_branch  (disp_is_branch),
        .disp_pred_taken (disp_pred_taken),
        .disp_alt_pc     (disp_alt_pc),
        .disp_tag        (disp_tag),
        .rob_full        (rob_full),
        .qry1_tag        (qry1_tag),
        .qry2_tag        (qry2_tag),
        .qry1_ready      (qry1_ready),
        .qry2_ready      (qry2_ready),
        .qry1_data       (qry1_data),
        .qry2_data       (qry2_data),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_data        (cdb_data),
        .cdb_taken       (cdb_taken),
        .commit_valid    (commit_valid),
        .commit_rd       (commit_rd),
        .commit_tag      (commit_tag),
        .commit_data     (commit_data),
        .wrong_commit    (wrong_commit),
        .flush_pc        (flush_pc)
`ifdef ROB_STAT_EN
        ,
        .stat_commits    (stat_commits),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        disp_valid      = 1'b0;
        disp_rd         = '0;
        disp_is_branch  = 1'b0;
        disp_pred_taken = 1'b0;
        disp_alt_pc     = '0;
        cdb_valid       = 1'b0;
        cdb_tag         = '0;
        cdb_data        = '0;
        cdb_taken       = 1'b0;
        qry1_tag        = '0;
        qry2_tag        = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rdy = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_disp(input logic [4:0] rd, input logic br, input logic pred,
                            input logic [31:0] alt);
        disp_valid      = 1'b1;
        disp_rd         = rd;
        disp_is_branch  = br;
        disp_pred_taken = pred;
        disp_alt_pc     = alt;
    endtask

    task automatic set_cdb(input logic [4:0] tag, input logic [31:0] data, input logic taken);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
        cdb_taken = taken;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        rdy = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({commit_valid, wrong_commit, commit_rd, commit_tag, commit_data, flush_pc, rob_full} !== 77'd0) begin
            failures++;
            $display("FAIL reset_outputs got cv=%0b wc=%0b rd=%0d tag=%0d data=%h pc=%h full=%0b want all 0",
                     commit_valid, wrong_commit, commit_rd, commit_tag, commit_data, flush_pc, rob_full);
        end
        checks++;
        if (disp_tag !== 5'd1) begin
            failures++;
            $display("FAIL reset_disp_tag got=%0d want=1", disp_tag);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({commit_valid, rob_full, disp_tag} !== {1'b0, 1'b0, 5'd1}) begin
            failures++;
            $display("FAIL reset_release got cv=%0b full=%0b tag=%0d want 0/0/1", commit_valid, rob_full, disp_tag);
        end
    endtask

    task automatic test_basic_commit();
        do_reset();
        set_disp(5'd5, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        disp_valid = 1'b0;
        set_cdb(5'd1, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        cdb_valid = 1'b0;
        checks++;
        if (commit_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_commit got=%0b want=0", commit_valid);
        end
        @(negedge clk);
        checks++;
        if ({commit_valid, commit_rd, commit_tag, commit_data, wrong_commit} !== {1'b1, 5'd5, 5'd1, 32'hDEADBEEF, 1'b0}) begin
            failures++;
            $display("FAIL basic_commit got cv=%0b rd=%0d tag=%0d data=%h wc=%0b want 1/5/1/deadbeef/0",
                     commit_valid, commit_rd, commit_tag, commit_data, wrong_commit);
        end
        @(negedge clk);
        checks++;
        if (commit_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_pulse_width got=%0b want=0", commit_valid);
        end
    endtask

    task automatic test_full_wrap();
        logic [41:0] exp;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_disp(5'(i + 1), 1'b0, 1'b0, 32'h0);
            checks++;
            if (disp_tag !== 5'(i + 1)) begin
                failures++;
                $display("FAIL fill_disp_tag got=%0d want=%0d", disp_tag, i + 1);
            end
            @(negedge clk);
        end
        // 17th request while full
        set_disp(5'd31, 1'b0, 1'b0, 32'h0);
        checks++;
        if (rob_full !== 1'b1) begin
            failures++;
            $display("FAIL full_flag got=%0b want=1", rob_full);
        end
        @(negedge clk);
        disp_valid = 1'b0;
        set_cdb(5'd1, 32'h101, 1'b0);
        @(negedge clk);
        cdb_valid = 1'b0;
        // Request on the retire edge while still full: must be refused
        set_disp(5'd9, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++;
        if ({commit_valid, commit_tag, commit_rd, commit_data} !== {1'b1, 5'd1, 5'd1, 32'h101}) begin
            failures++;
            $display("FAIL full_first_commit got cv=%0b tag=%0d rd=%0d data=%h want 1/1/1/101",
                     commit_valid, commit_tag, commit_rd, commit_data);
        end
        checks++;
        if ({rob_full, disp_tag} !== {1'b0, 5'd1}) begin
            failures++;
            $display("FAIL wrap_after_retire got full=%0b tag=%0d want 0/1", rob_full, disp_tag);
        end
        @(negedge clk);
        disp_valid = 1'b0;
        checks++;
        if (rob_full !== 1'b1) begin
            failures++;
            $display("FAIL refill_full got=%0b want=1", rob_full);
        end
        for (int k = 2; k <= 16; k++) exp_q.push_back({5'(k), 5'(k), 32'(32'h100 + k)});
        exp_q.push_back({5'd1, 5'd9, 32'h200});
        for (int c = 0; c < 24; c++) begin
            if (c < 15) set_cdb(5'(c + 2), 32'(32'h100 + c + 2), 1'b0);
            else if (c == 15) set_cdb(5'd1, 32'h200, 1'b0);
            else cdb_valid = 1'b0;
            @(negedge clk);
            if (commit_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL drain_extra_commit got tag=%0d rd=%0d want none", commit_tag, commit_rd);
                end else begin
                    exp = exp_q.pop_front();
                    if ({commit_tag, commit_rd, commit_data} !== exp) begin
                        failures++;
                        $display("FAIL drain_order got tag=%0d rd=%0d data=%h want tag=%0d rd=%0d data=%h",
                                 commit_tag, commit_rd, commit_data, exp[41:37], exp[36:32], exp[31:0]);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_missing got remaining=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if ({rob_full, disp_tag} !== {1'b0, 5'd2}) begin
            failures++;
            $display("FAIL drain_end got full=%0b tag=%0d want 0/2", rob_full, disp_tag);
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            set_disp(5'(i), 1'b0, 1'b0, 32'h0);
            @(negedge clk);
        end
        disp_valid = 1'b0;
        set_cdb(5'd3, 32'h33, 1'b0);
        @(negedge clk);
        set_cdb(5'd2, 32'h22, 1'b0);
        qry1_tag = 5'd3;
        qry2_tag = 5'd1;
        #1;
        checks++;
        if ({qry1_ready, qry1_data, qry2_ready, qry2_data} !== {1'b1, 32'h33, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL ooo_fwd got q1=%0b/%h q2=%0b/%h want 1/33 0/0", qry1_ready, qry1_data, qry2_ready, qry2_data);
        end
        @(negedge clk);
        qry1_tag = '0;
        qry2_tag = '0;
        set_cdb(5'd1, 32'h11, 1'b0);
        checks++;
        if (commit_valid !== 1'b0) begin
            failures++;
            $display("FAIL ooo_early_a got=%0b want=0", commit_valid);
        end
        @(negedge clk);
        cdb_valid = 1'b0;
        checks++;
        if (commit_valid !== 1'b0) begin
            failures++;
            $display("FAIL ooo_early_b got=%0b want=0", commit_valid);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if ({commit_valid, commit_tag, commit_rd, commit_data} !== {1'b1, 5'(i), 5'(i), 32'(i * 32'h11)}) begin
                failures++;
                $display("FAIL ooo_commit got cv=%0b tag=%0d rd=%0d data=%h want tag=%0d",
                         commit_valid, commit_tag, commit_rd, commit_data, i);
            end
        end
        @(negedge clk);
        checks++;
        if (commit_valid !== 1'b0) begin
            failures++;
            $display("FAIL ooo_tail_idle got=%0b want=0", commit_valid);
        end
    endtask

    task automatic test_mispredict();
        logic seen;
        do_reset();
        set_disp(5'd7, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        set_disp(5'd6, 1'b1, 1'b0, 32'h1000);
        @(negedge clk);
        set_disp(5'd8, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        disp_valid = 1'b0;
        set_cdb(5'd1, 32'hA1, 1'b0);
        @(negedge clk);
        set_cdb(5'd3, 32'hA3, 1'b0);
        @(negedge clk);
        checks++;
        if ({commit_valid, commit_tag, commit_rd, commit_data, wrong_commit} !== {1'b1, 5'd1, 5'd7, 32'hA1, 1'b0}) begin
            failures++;
            $display("FAIL mp_first_commit got cv=%0b tag=%0d rd=%0d data=%h wc=%0b want 1/1/7/a1/0",
                     commit_valid, commit_tag, commit_rd, commit_data, wrong_commit);
        end
        set_cdb(5'd2, 32'h0, 1'b1);
        @(negedge clk);
        cdb_valid = 1'b0;
        checks++;
        if (commit_valid !== 1'b0) begin
            failures++;
            $display("FAIL mp_gap got=%0b want=0", commit_valid);
        end
        // Dispatch on the flush edge must be dropped
        set_disp(5'd4, 1'b0, 1'b0, 32'h0);
        qry1_tag = 5'd3;
        #1;
        checks++;
        if ({qry1_ready, qry1_data} !== {1'b1, 32'hA3}) begin
            failures++;
            $display("FAIL mp_fwd_pre got %0b/%h want 1/a3", qry1_ready, qry1_data);
        end
        @(negedge clk);
        disp_valid = 1'b0;
        checks++;
        if ({commit_valid, wrong_commit, commit_rd, commit_tag, flush_pc} !== {1'b1, 1'b1, 5'd0, 5'd2, 32'h1000}) begin
            failures++;
            $display("FAIL mp_flush got cv=%0b wc=%0b rd=%0d tag=%0d pc=%h want 1/1/0/2/1000",
                     commit_valid, wrong_commit, commit_rd, commit_tag, flush_pc);
        end
        checks++;
        if ({disp_tag, rob_full, qry1_ready} !== {5'd1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mp_after_flush got tag=%0d full=%0b q1rdy=%0b want 1/0/0", disp_tag, rob_full, qry1_ready);
        end
        qry1_tag = '0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (commit_valid !== 1'b0 || wrong_commit !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL mp_flushed_commit got=1 want=0");
        end
        set_disp(5'd10, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        disp_valid = 1'b0;
        set_cdb(5'd1, 32'hBB, 1'b0);
        @(negedge clk);
        cdb_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({commit_valid, wrong_commit, commit_tag, commit_rd, commit_data} !== {1'b1, 1'b0, 5'd1, 5'd10, 32'hBB}) begin
            failures++;
            $display("FAIL mp_restart got cv=%0b wc=%0b tag=%0d rd=%0d data=%h want 1/0/1/10/bb",
                     commit_valid, wrong_commit, commit_tag, commit_rd, commit_data);
        end
`ifdef ROB_STAT_EN
        checks++;
        if ({stat_commits, stat_mispredicts} !== {32'd3, 32'd1}) begin
            failures++;
            $display("FAIL mp_stats got c=%0d m=%0d want 3/1", stat_commits, stat_mispredicts);
        end
`endif
    endtask

    task automatic test_forwarding();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            set_disp(5'(i + 10), 1'b0, 1'b0, 32'h0);
            @(negedge clk);
        end
        disp_valid = 1'b0;
        set_cdb(5'd4, 32'd7, 1'b0);
        qry1_tag = 5'd4;
        qry2_tag = 5'd0;
        #1;
        checks++;
        if ({qry1_ready, qry1_data, qry2_ready, qry2_data} !== {1'b1, 32'd7, 1'b1, 32'd0}) begin
            failures++;
            $display("FAIL fwd_bypass got q1=%0b/%0d q2=%0b/%0d want 1/7 1/0", qry1_ready, qry1_data, qry2_ready, qry2_data);
        end
        cdb_tag = 5'd3;
        #1;
        checks++;
        if ({qry1_ready, qry1_data} !== {1'b0, 32'd0}) begin
            failures++;
            $display("FAIL fwd_other_tag got %0b/%0d want 0/0", qry1_ready, qry1_data);
        end
        cdb_tag = 5'd4;
        @(negedge clk);
        cdb_valid = 1'b0;
        #1;
        checks++;
        if ({qry1_ready, qry1_data} !== {1'b1, 32'd7}) begin
            failures++;
            $display("FAIL fwd_stored got %0b/%0d want 1/7", qry1_ready, qry1_data);
        end
        drive_idle();
    endtask

    task automatic test_reset_midburst();
        logic seen;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            set_disp(5'(i), 1'b0, 1'b0, 32'h0);
            @(negedge clk);
        end
        disp_valid = 1'b0;
        set_cdb(5'd1, 32'h11, 1'b0);
        @(negedge clk);
        set_cdb(5'd2, 32'h22, 1'b0);
        @(negedge clk);
        cdb_valid = 1'b0;
        checks++;
        if ({commit_valid, commit_tag} !== {1'b1, 5'd1}) begin
            failures++;
            $display("FAIL rstmid_pre got cv=%0b tag=%0d want 1/1", commit_valid, commit_tag);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({commit_valid, commit_tag, commit_rd, commit_data, wrong_commit, flush_pc, rob_full, disp_tag} !==
            {1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd1}) begin
            failures++;
            $display("FAIL rstmid_async got cv=%0b tag=%0d rd=%0d data=%h full=%0b dtag=%0d want zeros dtag=1",
                     commit_valid, commit_tag, commit_rd, commit_data, rob_full, disp_tag);
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (commit_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || disp_tag !== 5'd1) begin
            failures++;
            $display("FAIL rstmid_after got commit_seen=%0b dtag=%0d want 0/1", seen, disp_tag);
        end
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        set_disp(5'd1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        set_disp(5'd2, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        disp_valid = 1'b0;
        set_cdb(5'd1, 32'h55, 1'b0);
        @(negedge clk);
        cdb_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({commit_valid, commit_tag} !== {1'b1, 5'd1}) begin
            failures++;
            $display("FAIL rdy_pre got cv=%0b tag=%0d want 1/1", commit_valid, commit_tag);
        end
        rdy = 1'b0;
        set_disp(5'd3, 1'b0, 1'b0, 32'h0);
        set_cdb(5'd2, 32'h66, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({commit_valid, commit_tag, commit_data, disp_tag} !== {1'b1, 5'd1, 32'h55, 5'd3}) begin
                failures++;
                $display("FAIL rdy_hold got cv=%0b tag=%0d data=%h dtag=%0d want 1/1/55/3",
                         commit_valid, commit_tag, commit_data, disp_tag);
            end
        end
        rdy = 1'b1;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({commit_valid, disp_tag} !== {1'b0, 5'd3}) begin
            failures++;
            $display("FAIL rdy_resume got cv=%0b dtag=%0d want 0/3", commit_valid, disp_tag);
        end
        set_cdb(5'd2, 32'h66, 1'b0);
        @(negedge clk);
        cdb_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({commit_valid, commit_tag, commit_rd, commit_data} !== {1'b1, 5'd2, 5'd2, 32'h66}) begin
            failures++;
            $display("FAIL rdy_second got cv=%0b tag=%0d rd=%0d data=%h want 1/2/2/66",
                     commit_valid, commit_tag, commit_rd, commit_data);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_commit();
        test_full_wrap();
        test_out_of_order();
        test_mispredict();
        test_forwarding();
        test_reset_midburst();
        test_rdy_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
